// File: rtl/tank_level_monitor.sv
// Multi-channel tank level monitor: per-channel debounce filter and latched
// alarm FSM with acknowledge, plus a scanning seven-segment digit.

module tank_level_chan #(
    parameter int FILTER = 3
) (
    input  logic       clk_2,
    input  logic       reset,
    input  logic [1:0] raw,
    input  logic       ack_edge,
    output logic [1:0] level,
    output logic [1:0] state
);
    localparam int CW = $clog2(FILTER + 1);
    localparam logic [1:0] ST_OK    = 2'b00;
    localparam logic [1:0] ST_ALARM = 2'b01;
    localparam logic [1:0] ST_ACKED = 2'b10;

    logic [1:0]    last_raw_q, last_raw_d;
    logic [1:0]    level_q, level_d;
    logic [1:0]    state_q, state_d;
    logic [1:0]    acked_q, acked_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cond;

    always_comb begin
        if (raw == last_raw_q)
            cnt_d = (cnt_q == CW'(FILTER)) ? cnt_q : cnt_q + CW'(1);
        else
            cnt_d = CW'(1);
        last_raw_d = raw;
        level_d    = (cnt_d == CW'(FILTER)) ? raw : level_q;
    end

    assign cond = level_q[1];

    // acked_q remembers which alarm code was acknowledged, so a swap to the
    // other alarm code re-raises the alarm.
    always_comb begin
        state_d = state_q;
        acked_d = acked_q;
        case (state_q)
            ST_ALARM: begin
                if (ack_edge) begin
                    state_d = cond ? ST_ACKED : ST_OK;
                    acked_d = level_q;
                end
            end
            ST_ACKED: begin
                if (!cond)
                    state_d = ST_OK;
                else if (level_q != acked_q)
                    state_d = ST_ALARM;
            end
            default: begin
                if (cond)
                    state_d = ST_ALARM;
            end
        endcase
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            last_raw_q <= 2'b01;
            cnt_q      <= '0;
            level_q    <= 2'b01;
            state_q    <= ST_OK;
            acked_q    <= 2'b00;
        end else begin
            last_raw_q <= last_raw_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            state_q    <= state_d;
            acked_q    <= acked_d;
        end
    end

    assign level = level_q;
    assign state = state_q;
endmodule

module tank_level_monitor #(
    parameter int NCH         = 4,
    parameter int FILTER      = 3,
    parameter int SCAN_CYCLES = 2
) (
    input  logic                     clk_2,
    input  logic                     reset,
    input  logic [2*NCH-1:0]         sensors,
    input  logic                     ack,
    output logic [2*NCH-1:0]         level,
    output logic [$clog2(NCH)-1:0]   chan,
    output logic [7:0]               seg,
    output logic                     alarm,
    output logic [2*NCH-1:0]         state
);
    localparam int CHW = $clog2(NCH);
    localparam int TW  = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;

    logic           ack_q, ack_d;
    logic           ack_edge;
    logic [TW-1:0]  tick_q, tick_d;
    logic [CHW-1:0] chan_q, chan_d;
    logic [CHW-1:0] low_idx;
    logic [NCH-1:0] alarm_vec;
    logic [1:0]     disp_lvl, disp_st;
    logic [6:0]     letter;

    assign ack_edge = ack & ~ack_q;
    assign ack_d    = ack;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        tank_level_chan #(.FILTER(FILTER)) u_ch (
            .clk_2    (clk_2),
            .reset    (reset),
            .raw      (sensors[2*k +: 2]),
            .ack_edge (ack_edge),
            .level    (level[2*k +: 2]),
            .state    (state[2*k +: 2])
        );
        assign alarm_vec[k] = (state[2*k +: 2] == 2'b01);
    end

    assign alarm = |alarm_vec;

    always_comb begin
        low_idx = '0;
        for (int k = NCH - 1; k >= 0; k--)
            if (alarm_vec[k])
                low_idx = CHW'(k);
    end

    // An active alarm pins the display and holds the dwell counter at zero,
    // so scanning restarts from that channel with a full dwell.
    always_comb begin
        tick_d = tick_q;
        chan_d = chan_q;
        if (alarm) begin
            tick_d = '0;
            chan_d = low_idx;
        end else if (tick_q == TW'(SCAN_CYCLES - 1)) begin
            tick_d = '0;
            chan_d = (chan_q == CHW'(NCH - 1)) ? '0 : chan_q + CHW'(1);
        end else begin
            tick_d = tick_q + TW'(1);
        end
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            ack_q  <= 1'b0;
            tick_q <= '0;
            chan_q <= '0;
        end else begin
            ack_q  <= ack_d;
            tick_q <= tick_d;
            chan_q <= chan_d;
        end
    end

    assign disp_lvl = level[2*chan_q +: 2];
    assign disp_st  = state[2*chan_q +: 2];

    always_comb begin
        case (disp_lvl)
            2'b00:   letter = 7'h77;
            2'b01:   letter = 7'h54;
            2'b10:   letter = 7'h7C;
            default: letter = 7'h5E;
        endcase
    end

    assign seg  = {disp_st != 2'b00, letter};
    assign chan = chan_q;
endmodule

// File: tb/tb_tank_level_monitor.sv
// Directed bench for tank_level_monitor (NCH=4, FILTER=3, SCAN_CYCLES=2).

module tb_tank_level_monitor;
    logic       clk_2 = 1'b0;
    logic       reset;
    logic [7:0] sensors;
    logic       ack;
    logic [7:0] level;
    logic [1:0] chan;
    logic [7:0] seg;
    logic       alarm;
    logic [7:0] state;

    int n_assert = 0;
    int n_fail   = 0;

    tank_level_monitor #(.NCH(4), .FILTER(3), .SCAN_CYCLES(2)) dut (
        .clk_2   (clk_2),
        .reset   (reset),
        .sensors (sensors),
        .ack     (ack),
        .level   (level),
        .chan    (chan),
        .seg     (seg),
        .alarm   (alarm),
        .state   (state)
    );

    always #5 clk_2 = ~clk_2;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_2);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    int exp_chan [8] = '{0, 1, 1, 2, 2, 3, 3, 0};

    initial begin
        reset = 1'b1; sensors = 8'h55; ack = 1'b0;
        step(2);
        chk("rst_level", level, 8'h55);
        chk("rst_chan", chan, 0);
        chk("rst_seg", seg, 8'h54);
        chk("rst_alarm", alarm, 0);
        chk("rst_state", state, 8'h00);
        reset = 1'b0;

        // idle scan
        for (int i = 0; i < 8; i++) begin
            step();
            chk("scan_chan", chan, exp_chan[i]);
            chk("scan_seg", seg, 8'h54);
            chk("scan_alarm", alarm, 0);
        end

        // ch2 glitch of two samples is rejected
        sensors = 8'h65; step(2);
        sensors = 8'h55; step(2);
        chk("glitch_level", level, 8'h55);

        // ch2 held at 10
        sensors = 8'h65; step(2);
        chk("filt2_level", level, 8'h55);
        step();
        chk("filt3_level", level, 8'h65);
        chk("filt3_state", state, 8'h00);
        chk("filt3_alarm", alarm, 0);
        step();
        chk("ch2_state", state, 8'h10);
        chk("ch2_alarm", alarm, 1);
        step();
        chk("ch2_chan", chan, 2);
        chk("ch2_seg", seg, 8'hFC);

        // condition clears, alarm stays latched
        sensors = 8'h55; step(4);
        chk("latch_level", level, 8'h55);
        chk("latch_state", state, 8'h10);
        chk("latch_alarm", alarm, 1);
        chk("latch_seg", seg, 8'hD4);
        ack = 1'b1; step();
        chk("ack_state", state, 8'h00);
        chk("ack_alarm", alarm, 0);
        chk("ack_chan0", chan, 2);
        ack = 1'b0; step();
        chk("ack_chan1", chan, 2);
        step();
        chk("ack_chan2", chan, 3);

        // ch1=11 and ch3=10
        sensors = 8'h9D; step(3);
        chk("dual_level", level, 8'h9D);
        step();
        chk("dual_state", state, 8'h44);
        chk("dual_alarm", alarm, 1);
        step();
        chk("dual_chan", chan, 1);
        chk("dual_seg", seg, 8'hDE);
        ack = 1'b1; step();
        chk("dual_ack_state", state, 8'h88);
        chk("dual_ack_alarm", alarm, 0);
        chk("dual_ack_seg", seg, 8'hDE);
        ack = 1'b0; step(2);
        chk("acked_chan2", chan, 2);
        chk("acked_seg2", seg, 8'h54);
        step(2);
        chk("acked_chan3", chan, 3);
        chk("acked_seg3", seg, 8'hFC);

        // ch3 swaps 10 -> 11 while acked
        sensors = 8'hDD; step(4);
        chk("swap_state", state, 8'h48);
        chk("swap_alarm", alarm, 1);
        step();
        chk("swap_chan", chan, 3);
        chk("swap_seg", seg, 8'hDE);

        // return everything to OK
        sensors = 8'h55; step(4);
        chk("clr_state", state, 8'h40);
        ack = 1'b1; step();
        ack = 1'b0; step();
        chk("clr_state2", state, 8'h00);
        chk("clr_alarm", alarm, 0);

        // ack held high while ch0 enters alarm
        ack = 1'b1; step();
        sensors = 8'h56; step(4);
        chk("hold_state", state, 8'h01);
        step(5);
        chk("hold_state2", state, 8'h01);
        chk("hold_alarm", alarm, 1);
        ack = 1'b0; step();
        ack = 1'b1; step();
        chk("reack_state", state, 8'h02);
        chk("reack_alarm", alarm, 0);
        ack = 1'b0;

        // ch0 -> 11 raises alarm, ch1 mid-filter, then reset
        sensors = 8'h57; step(4);
        chk("pre_rst_state", state, 8'h01);
        sensors = 8'h5B; step();
        reset = 1'b1; step();
        chk("mid_rst_level", level, 8'h55);
        chk("mid_rst_state", state, 8'h00);
        chk("mid_rst_alarm", alarm, 0);
        chk("mid_rst_chan", chan, 0);
        chk("mid_rst_seg", seg, 8'h54);
        reset = 1'b0; step(2);
        chk("post_rst_filt", level, 8'h55);
        step();
        chk("post_rst_level", level, 8'h5B);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
